// File: rtl/pipe_alu.sv
// Execute-stage integer ALU: 16 operations on A, B and a shift amount, with the
// result and zero flag registered for one cycle of latency into EX/MEM.
module pipe_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a_input,
   input  logic [WIDTH-1:0] b_input,
   input  logic [4:0]       sa,
   input  logic [3:0]       opcode,
   output logic [WIDTH-1:0] resultado,
   output logic             zero
);

   typedef enum logic [3:0] {
      OP_ADD   = 4'b0000,
      OP_SUB   = 4'b0001,
      OP_AND   = 4'b0010,
      OP_OR    = 4'b0011,
      OP_XOR   = 4'b0100,
      OP_NOR   = 4'b0101,
      OP_SLT   = 4'b0110,
      OP_SLTU  = 4'b0111,
      OP_SLLV  = 4'b1000,
      OP_SRLV  = 4'b1001,
      OP_SRAV  = 4'b1010,
      OP_LUI   = 4'b1011,
      OP_SLL   = 4'b1100,
      OP_SRL   = 4'b1101,
      OP_PASSA = 4'b1110,
      OP_SRA   = 4'b1111
   } op_t;

   op_t              op;
   logic [4:0]       var_count;
   logic             lt_signed;
   logic             lt_unsigned;
   logic [WIDTH-1:0] result_next;
   logic             zero_next;

   assign op          = op_t'(opcode);
   // Variable shifts only honour the low five bits of A.
   assign var_count   = a_input[4:0];
   // Direct signed compare; deriving it from the sign of A-B breaks on overflow.
   assign lt_signed   = $signed(a_input) < $signed(b_input);
   assign lt_unsigned = a_input < b_input;

   always_comb begin
      result_next = '0;
      case (op)
         OP_ADD:   result_next = a_input + b_input;
         OP_SUB:   result_next = a_input - b_input;
         OP_AND:   result_next = a_input & b_input;
         OP_OR:    result_next = a_input | b_input;
         OP_XOR:   result_next = a_input ^ b_input;
         OP_NOR:   result_next = ~(a_input | b_input);
         OP_SLT:   result_next = {{(WIDTH-1){1'b0}}, lt_signed};
         OP_SLTU:  result_next = {{(WIDTH-1){1'b0}}, lt_unsigned};
         OP_SLLV:  result_next = b_input << var_count;
         OP_SRLV:  result_next = b_input >> var_count;
         OP_SRAV:  result_next = $unsigned($signed(b_input) >>> var_count);
         OP_LUI:   result_next = {b_input[15:0], 16'h0000};
         OP_SLL:   result_next = b_input << sa;
         OP_SRL:   result_next = b_input >> sa;
         OP_PASSA: result_next = a_input;
         OP_SRA:   result_next = $unsigned($signed(b_input) >>> sa);
         default:  result_next = '0;
      endcase
   end

   assign zero_next = (result_next == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         resultado <= '0;
         zero      <= 1'b1;
      end else begin
         resultado <= result_next;
         zero      <= zero_next;
      end
   end

endmodule

// File: tb/tb_pipe_alu.sv
// Scoreboard bench for pipe_alu: stimulus pushes hand-computed results, a monitor
// pops one entry per launched operation and compares it one cycle later.
module tb_pipe_alu;

   logic        clk;
   logic        reset;
   logic [31:0] a_input;
   logic [31:0] b_input;
   logic [4:0]  sa;
   logic [3:0]  opcode;
   logic [31:0] resultado;
   logic        zero;

   logic        issue_valid;
   int          tests_run;
   int          tests_failed;

   typedef struct {
      logic [31:0] res;
      logic        zf;
      string       name;
   } exp_t;

   exp_t exp_q[$];

   pipe_alu #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .a_input   (a_input),
      .b_input   (b_input),
      .sa        (sa),
      .opcode    (opcode),
      .resultado (resultado),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act_res, input logic act_z,
                        input logic [31:0] req_res, input logic req_z);
      tests_run++;
      if (act_res !== req_res || act_z !== req_z) begin
         tests_failed++;
         $display("[TB] FAIL %s: got resultado=%08h zero=%0b, expected resultado=%08h zero=%0b",
                  name, act_res, act_z, req_res, req_z);
      end else begin
         $display("[TB] ok   %s: resultado=%08h zero=%0b", name, act_res, act_z);
      end
   endtask

   // Drive one operation for a full cycle and record what it must produce.
   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] s, input logic [31:0] res, input string name);
      exp_t e;
      @(posedge clk);
      #1;
      opcode      = op;
      a_input     = a;
      b_input     = b;
      sa          = s;
      issue_valid = 1'b1;
      e.res  = res;
      e.zf   = (res == 32'h0);
      e.name = name;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      issue_valid = 1'b0;
   endtask

   // Monitor: an operation present at a rising edge is checked on the following falling edge.
   initial begin
      logic launched;
      exp_t e;
      forever begin
         @(posedge clk);
         launched = issue_valid && !reset;
         @(negedge clk);
         if (launched) begin
            if (exp_q.size() == 0) begin
               tests_run++;
               tests_failed++;
               $display("[TB] FAIL scoreboard_underflow: got output %08h, expected no pending entry", resultado);
            end else begin
               e = exp_q.pop_front();
               check(e.name, resultado, zero, e.res, e.zf);
            end
         end
      end
   end

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      issue_valid  = 1'b0;
      opcode       = 4'b0000;
      a_input      = 32'd5;
      b_input      = 32'd3;
      sa           = 5'd0;
      reset        = 1'b1;
      #2;
      check("reset_initial", resultado, zero, 32'h0, 1'b1);
      @(posedge clk);
      #1;
      check("reset_holds_inputs_ignored", resultado, zero, 32'h0, 1'b1);
      reset = 1'b0;

      // Logic, misc, arithmetic: back-to-back, a new result every cycle.
      issue(4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000, "and");
      issue(4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hFFF0FFF0, "or");
      issue(4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'h0FF00FF0, "xor");
      issue(4'b0101, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'h000F000F, "nor");
      issue(4'b1110, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF0F0F0F0, "passa");
      issue(4'b1011, 32'h00000000, 32'h00001234, 5'd0, 32'h12340000, "lui");
      issue(4'b0000, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, "add_ovf");
      issue(4'b0000, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, "add_wrap_zero");
      issue(4'b0001, 32'h00001234, 32'h00001234, 5'd0, 32'h00000000, "sub_zero");
      issue(4'b0001, 32'h00000003, 32'h00000005, 5'd0, 32'hFFFFFFFE, "sub_neg");
      issue(4'b0110, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000001, "slt_neg");
      issue(4'b0111, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, "sltu");
      issue(4'b0110, 32'h80000000, 32'h7FFFFFFF, 5'd0, 32'h00000001, "slt_extreme");
      issue(4'b0110, 32'h7FFFFFFF, 32'h80000000, 5'd0, 32'h00000000, "slt_extreme_rev");
      // SRA sweep of a negative value.
      issue(4'b1111, 32'h0, 32'hFFFFFFFE, 5'd0, 32'hFFFFFFFE, "sra_sa0");
      issue(4'b1111, 32'h0, 32'hFFFFFFFE, 5'd1, 32'hFFFFFFFF, "sra_sa1");
      issue(4'b1111, 32'h0, 32'hFFFFFFFE, 5'd2, 32'hFFFFFFFF, "sra_sa2");
      issue(4'b1111, 32'h0, 32'hFFFFFFFE, 5'd3, 32'hFFFFFFFF, "sra_sa3");
      // Logical vs arithmetic shifts.
      issue(4'b1101, 32'h0, 32'h80000000, 5'd4, 32'h08000000, "srl_sa4");
      issue(4'b1111, 32'h0, 32'h80000000, 5'd4, 32'hF8000000, "sra_sa4");
      issue(4'b1100, 32'h0, 32'h00000001, 5'd31, 32'h80000000, "sll_sa31");
      issue(4'b1010, 32'h00000024, 32'h80000000, 5'd0, 32'hF8000000, "srav_cnt4");
      issue(4'b1000, 32'hFFFFFFE5, 32'h00000001, 5'd0, 32'h00000020, "sllv_cnt5");
      issue(4'b1001, 32'h0000001F, 32'h80000000, 5'd0, 32'h00000001, "srlv_cnt31");
      issue(4'b1010, 32'h00000020, 32'h80000001, 5'd7, 32'h80000001, "srav_cnt0");
      issue(4'b1111, 32'h0, 32'h80000000, 5'd31, 32'hFFFFFFFF, "sra_sa31");
      issue(4'b1101, 32'h0, 32'h80000000, 5'd31, 32'h00000001, "srl_sa31");
      idle();

      // Mid-stream reset clears outputs without a clock edge.
      @(posedge clk);
      #2;
      opcode  = 4'b0000;
      a_input = 32'd5;
      b_input = 32'd3;
      reset   = 1'b1;
      #1;
      check("reset_async_midstream", resultado, zero, 32'h0, 1'b1);
      @(posedge clk);
      #1;
      check("reset_held_over_edge", resultado, zero, 32'h0, 1'b1);
      reset = 1'b0;
      begin
         exp_t e;
         e.res  = 32'd8;
         e.zf   = 1'b0;
         e.name = "first_after_reset";
         exp_q.push_back(e);
         issue_valid = 1'b1;
      end
      issue(4'b0001, 32'd5, 32'd3, 5'd0, 32'd2, "sub_after_reset");
      idle();

      repeat (4) @(posedge clk);
      #1;
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #20000;
      $display("[TB] FAIL timeout: got no completion by 20000, expected finish");
      $fatal(1, "timeout");
   end

endmodule
